line_packet_receiver: RTL and testbench
=======================================

# line_packet_receiver

Receive side of the FPGA1→FPGA2 2-bit line link. Deserializes dibit frames (24-bit start address, then pixel bytes, optionally audio bytes) and drives a write port into the lightboard frame BRAM. Sits on FPGA2 directly behind the inter-board pins, one clock domain with the link.

## Interface
- PIXELS_PER_LINE, 320, pixel bytes per frame.
- ADDR_W, 17, width of the BRAM write address; the received 24-bit start address is truncated to its low ADDR_W bits.

- clk  in  1  system clock; link sampled on rising edge.
- rst  in  1  reset, synchronous, active-low (asserted when 0).
- axiiv  in  1  link valid; high for the whole frame, no gaps.
- axiid  in  2  link data dibit.
- pixel_wr_en  out  1  one-cycle write strobe.
- pixel_wr_addr  out  ADDR_W  write address.
- pixel_wr_data  out  8  pixel byte.
- line_done  out  1  one-cycle pulse: frame ended with exactly PIXELS_PER_LINE pixels received.
- frame_err  out  1  one-cycle pulse: frame ended short, mid-byte, or during address.
- audio_valid  out  1  one-cycle strobe (AUDIO_RX_EN only; tied 0 otherwise).
- audio_data  out  8  audio byte (AUDIO_RX_EN only; tied 0 otherwise).

## Operation
- Bit order, per byte: dibits arrive LSB first, i.e. bits [1:0], [3:2], [5:4], [7:6].
- Frame: 12 address dibits (byte [23:16], then [15:8], then [7:0]), then 4·PIXELS_PER_LINE pixel dibits, then (optionally) audio dibits until axiiv falls.
- States: IDLE, ADDR, PIXEL, AUDIO, DRAIN.
  - IDLE → ADDR on axiiv rising edge only (axiiv=1 and registered previous axiiv=0). The first dibit is captured in that same cycle.
  - ADDR: shift in 12 dibits. After the 12th, latch base = addr[ADDR_W-1:0] and go → PIXEL.
  - PIXEL: every 4th dibit completes a byte. Write it at base+k, where k = 0..PIXELS_PER_LINE-1 and the sum wraps modulo 2^ADDR_W. After byte PIXELS_PER_LINE-1, go → AUDIO if AUDIO_RX_EN, else → DRAIN.
  - AUDIO: every 4th dibit emits audio_valid/audio_data. No upper bound.
  - DRAIN: ignore dibits until axiiv=0.
- Frame end is the first cycle with axiiv=0 while in ADDR/PIXEL/AUDIO/DRAIN; next state is IDLE.
  - line_done pulses if the pixel count equals PIXELS_PER_LINE and no partial byte is pending.
  - frame_err pulses otherwise: end in ADDR, end in PIXEL, or a partial audio byte. Partial bytes are discarded and never written.
- The dibit and byte counters reset on every frame start.

## Timing
- Reset values: all outputs 0. State = IDLE. Previous-axiiv register = 1, so a frame already in progress when reset releases is ignored until axiiv goes low.
- Write latency: pixel_wr_en/addr/data are registered and valid in the cycle after the clock edge that samples the 4th dibit of the byte. Same latency for audio_valid.
- Throughput: one byte per 4 cycles. pixel_wr_en is never high two cycles in a row.
- line_done/frame_err are asserted the cycle after the first axiiv=0 sample. They are mutually exclusive.
- A one-cycle axiiv drop ends the frame. A new frame may start on the cycle after the drop; this is legal back-to-back operation.
- rst asserted mid-frame: all outputs are 0 in the next cycle, no further writes occur, and no done/err pulse is generated.

## Configuration
- AUDIO_RX_EN defined: AUDIO state is present. Bytes after the pixel field are output on audio_valid/audio_data, and a partial trailing audio byte raises frame_err.
- AUDIO_RX_EN undefined: AUDIO state is removed. PIXEL goes directly to DRAIN, trailing dibits are silently ignored, and audio_valid/audio_data are constant 0.

## Structure
- Shared package (line_link_pkg): the state enum, the ADDR_DIBITS=12 and DIBITS_PER_BYTE=4 constants, and the default PIXELS_PER_LINE. The FPGA1 serializer uses the same package.
- One sub-module: dibit_byte_assembler. It takes valid, dibit and a clear input, and produces a byte plus a byte_valid strobe. The address capture uses it three times in sequence.

## Test plan
- Address 0x000140 plus 320 pixels with value (k mod 256): 320 writes at addresses 0x140..0x27F with data k[7:0]; one line_done; no frame_err.
- Address 0x01FFF0 with ADDR_W=17: write 16 goes to address 0x00000 (wrap); line_done.
- axiiv drops after 100 pixels plus 2 dibits: exactly 100 writes, then frame_err; no line_done.
- axiiv drops after 8 address dibits: no writes; frame_err.
- rst held low for 2 cycles at pixel 50 while axiiv stays high: no writes after reset and no pulses. The next frame, started after an axiiv low, is received correctly.
- AUDIO_RX_EN with 320 pixels plus 8 audio dibits 0xA5, 0x3C (LSB-first): audio_valid pulses twice with 0xA5 then 0x3C, then line_done. Without the macro, the same stimulus gives line_done and no audio_valid.

Source files
------------

// File: rtl/line_link_pkg.sv
// Shared definitions for the FPGA1->FPGA2 2-bit line link, used by both the serializer and
// the receiver.
package line_link_pkg;

    localparam int unsigned ADDR_DIBITS             = 12;
    localparam int unsigned DIBITS_PER_BYTE         = 4;
    localparam int unsigned ADDR_BYTES              = ADDR_DIBITS / DIBITS_PER_BYTE;
    localparam int unsigned PIXELS_PER_LINE_DEFAULT = 320;

    typedef logic [2:0] link_state_t;

    localparam link_state_t ST_IDLE  = 3'd0;
    localparam link_state_t ST_ADDR  = 3'd1;
    localparam link_state_t ST_PIXEL = 3'd2;
    localparam link_state_t ST_AUDIO = 3'd3;
    localparam link_state_t ST_DRAIN = 3'd4;

endpackage

// File: rtl/dibit_byte_assembler.sv
// Collects LSB-first dibits into bytes; byte_o/byte_valid_o are combinational on the 4th dibit.
module dibit_byte_assembler
    import line_link_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clear_i,
    input  logic       valid_i,
    input  logic [1:0] dibit_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       pending_o
);

    localparam int unsigned CntW = $clog2(DIBITS_PER_BYTE);
    localparam int unsigned ShW  = 2 * (DIBITS_PER_BYTE - 1);

    logic [CntW-1:0] cnt_q, cnt_d, cnt_base;
    logic [ShW-1:0]  sh_q, sh_d;

    always_comb begin
        // clear restarts the byte while still accepting a dibit in the same cycle
        cnt_base     = clear_i ? '0 : cnt_q;
        cnt_d        = cnt_base;
        sh_d         = sh_q;
        byte_valid_o = 1'b0;
        byte_o       = {dibit_i, sh_q};
        if (valid_i) begin
            if (cnt_base == CntW'(DIBITS_PER_BYTE - 1)) begin
                byte_valid_o = 1'b1;
                cnt_d        = '0;
            end else begin
                sh_d  = {dibit_i, sh_q[ShW-1:2]};
                cnt_d = cnt_base + 1'b1;
            end
        end
    end

    assign pending_o = (cnt_q != '0);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            sh_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            sh_q  <= sh_d;
        end
    end

endmodule

// File: rtl/line_packet_receiver.sv
// Receive side of the 2-bit line link: address + pixel (+ audio) frames into a BRAM write port.
// Define AUDIO_RX_EN to emit bytes following the pixel field on audio_valid/audio_data.
module line_packet_receiver
    import line_link_pkg::*;
#(
    parameter int unsigned PIXELS_PER_LINE = PIXELS_PER_LINE_DEFAULT,
    parameter int unsigned ADDR_W          = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              axiiv,
    input  logic [1:0]        axiid,
    output logic              pixel_wr_en,
    output logic [ADDR_W-1:0] pixel_wr_addr,
    output logic [7:0]        pixel_wr_data,
    output logic              line_done,
    output logic              frame_err,
    output logic              audio_valid,
    output logic [7:0]        audio_data
);

    localparam int unsigned PixCntW = $clog2(PIXELS_PER_LINE + 1);

    link_state_t        state_q, state_d;
    logic               prev_v_q;
    logic [ADDR_W-9:0]  addr_q, addr_d;
    logic [1:0]         addr_cnt_q, addr_cnt_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [PixCntW-1:0] pix_cnt_q, pix_cnt_d;
    logic               wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [7:0]         wr_data_q, wr_data_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
`ifdef AUDIO_RX_EN
    logic               audio_valid_q, audio_valid_d;
    logic [7:0]         audio_data_q, audio_data_d;
`endif

    logic              frame_start;
    logic              asm_clear;
    logic              asm_valid;
    logic              byte_valid;
    logic              pending;
    logic [7:0]        asm_byte;
    logic [ADDR_W-1:0] addr_next;

    assign frame_start = axiiv & ~prev_v_q;
    assign asm_clear   = (state_q == ST_IDLE);
    assign asm_valid   = axiiv & ((asm_clear & frame_start) |
                                  (state_q inside {ST_ADDR, ST_PIXEL, ST_AUDIO}));
    // Only the low ADDR_W bits of the 24-bit address survive the shift.
    assign addr_next   = {addr_q, asm_byte};

    dibit_byte_assembler u_assembler (
        .clk_i       (clk),
        .rst_ni      (rst),
        .clear_i     (asm_clear),
        .valid_i     (asm_valid),
        .dibit_i     (axiid),
        .byte_o      (asm_byte),
        .byte_valid_o(byte_valid),
        .pending_o   (pending)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        addr_cnt_d = addr_cnt_q;
        base_d     = base_q;
        pix_cnt_d  = pix_cnt_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
`ifdef AUDIO_RX_EN
        audio_valid_d = 1'b0;
        audio_data_d  = audio_data_q;
`endif

        if (state_q != ST_IDLE && !axiiv) begin
            state_d = ST_IDLE;
            if ((state_q == ST_AUDIO || state_q == ST_DRAIN) && !pending) begin
                done_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (frame_start) begin
                        state_d    = ST_ADDR;
                        addr_cnt_d = '0;
                        pix_cnt_d  = '0;
                    end
                end
                ST_ADDR: begin
                    if (byte_valid) begin
                        addr_d     = addr_next[ADDR_W-9:0];
                        addr_cnt_d = addr_cnt_q + 1'b1;
                        if (addr_cnt_q == 2'(ADDR_BYTES - 1)) begin
                            base_d  = addr_next;
                            state_d = ST_PIXEL;
                        end
                    end
                end
                ST_PIXEL: begin
                    if (byte_valid) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = base_q + ADDR_W'(pix_cnt_q);
                        wr_data_d = asm_byte;
                        pix_cnt_d = pix_cnt_q + 1'b1;
                        if (pix_cnt_q == PixCntW'(PIXELS_PER_LINE - 1)) begin
`ifdef AUDIO_RX_EN
                            state_d = ST_AUDIO;
`else
                            state_d = ST_DRAIN;
`endif
                        end
                    end
                end
`ifdef AUDIO_RX_EN
                ST_AUDIO: begin
                    if (byte_valid) begin
                        audio_valid_d = 1'b1;
                        audio_data_d  = asm_byte;
                    end
                end
`endif
                ST_DRAIN: begin
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            prev_v_q   <= 1'b1;
            addr_q     <= '0;
            addr_cnt_q <= '0;
            base_q     <= '0;
            pix_cnt_q  <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef AUDIO_RX_EN
            audio_valid_q <= 1'b0;
            audio_data_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            prev_v_q   <= axiiv;
            addr_q     <= addr_d;
            addr_cnt_q <= addr_cnt_d;
            base_q     <= base_d;
            pix_cnt_q  <= pix_cnt_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef AUDIO_RX_EN
            audio_valid_q <= audio_valid_d;
            audio_data_q  <= audio_data_d;
`endif
        end
    end

    assign pixel_wr_en   = wr_en_q;
    assign pixel_wr_addr = wr_addr_q;
    assign pixel_wr_data = wr_data_q;
    assign line_done     = done_q;
    assign frame_err     = err_q;
`ifdef AUDIO_RX_EN
    assign audio_valid   = audio_valid_q;
    assign audio_data    = audio_data_q;
`else
    assign audio_valid   = 1'b0;
    assign audio_data    = 8'h00;
`endif

endmodule

// File: tb/tb_line_packet_receiver.sv
// Directed bench for line_packet_receiver: a cycle-indexed expectation table built from the
// frame layout, checked every cycle, plus literal per-frame checks.
module tb_line_packet_receiver;

    localparam int unsigned PPL    = 320;
    localparam int unsigned AW     = 17;
    localparam int          MaxCyc = 16384;
    localparam int          Full   = 4 * (3 + PPL);

    logic          clk = 1'b0;
    logic          rst;
    logic          axiiv;
    logic [1:0]    axiid;
    logic          pixel_wr_en;
    logic [AW-1:0] pixel_wr_addr;
    logic [7:0]    pixel_wr_data;
    logic          line_done;
    logic          frame_err;
    logic          audio_valid;
    logic [7:0]    audio_data;

    always #5 clk = ~clk;

    line_packet_receiver #(
        .PIXELS_PER_LINE(PPL),
        .ADDR_W         (AW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .axiiv        (axiiv),
        .axiid        (axiid),
        .pixel_wr_en  (pixel_wr_en),
        .pixel_wr_addr(pixel_wr_addr),
        .pixel_wr_data(pixel_wr_data),
        .line_done    (line_done),
        .frame_err    (frame_err),
        .audio_valid  (audio_valid),
        .audio_data   (audio_data)
    );

    // Expectations indexed by the number of rising edges seen so far.
    bit          exp_en   [MaxCyc];
    bit [AW-1:0] exp_addr [MaxCyc];
    bit [7:0]    exp_data [MaxCyc];
    bit          exp_done [MaxCyc];
    bit          exp_err  [MaxCyc];
    bit          exp_av   [MaxCyc];
    bit [7:0]    exp_ad   [MaxCyc];
    bit          exp_zero [MaxCyc];

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    logic [AW-1:0] wr_log_addr [$];
    logic [7:0]    wr_log_data [$];
    logic [7:0]    av_log      [$];
    int            done_cnt = 0;
    int            err_cnt  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s at edge %0d: got 0x%0h, want 0x%0h", name, cyc, got, want);
    endtask

    function automatic logic [31:0] log_addr(input int idx);
        return (idx < wr_log_addr.size()) ? 32'(wr_log_addr[idx]) : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] log_data(input int idx);
        return (idx < wr_log_data.size()) ? 32'(wr_log_data[idx]) : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] log_av(input int idx);
        return (idx < av_log.size()) ? 32'(av_log[idx]) : 32'hDEAD_BEEF;
    endfunction

    task automatic compare_slot();
        int c;
        c = cyc;
        check("wr_en", 32'(pixel_wr_en), 32'(exp_en[c]));
        if (exp_en[c] || exp_zero[c]) begin
            check("wr_addr", 32'(pixel_wr_addr), 32'(exp_addr[c]));
            check("wr_data", 32'(pixel_wr_data), 32'(exp_data[c]));
        end
        check("line_done", 32'(line_done), 32'(exp_done[c]));
        check("frame_err", 32'(frame_err), 32'(exp_err[c]));
        check("audio_valid", 32'(audio_valid), 32'(exp_av[c]));
`ifdef AUDIO_RX_EN
        if (exp_av[c] || exp_zero[c]) check("audio_data", 32'(audio_data), 32'(exp_ad[c]));
`else
        check("audio_data", 32'(audio_data), 32'h0);
`endif
        if (pixel_wr_en === 1'b1) begin
            wr_log_addr.push_back(pixel_wr_addr);
            wr_log_data.push_back(pixel_wr_data);
        end
        if (audio_valid === 1'b1) av_log.push_back(audio_data);
        if (line_done === 1'b1) done_cnt++;
        if (frame_err === 1'b1) err_cnt++;
    endtask

    task automatic step(input logic r, input logic v, input logic [1:0] d);
        if (cyc + 1 >= MaxCyc) begin
            $display("FAIL cycle_budget: got %0d edges, limit %0d", cyc + 1, MaxCyc);
            $display("%0d/%0d checks passed", n_pass, n_total + 1);
            $fatal(1, "cycle budget exhausted");
        end
        if (!r) exp_zero[cyc + 1] = 1'b1;
        rst   = r;
        axiiv = v;
        axiid = d;
        @(posedge clk);
        cyc++;
        #1;
        compare_slot();
    endtask

    // Sends the first n_dibits of {addr, PPL pixels (k ^ seed), a0, a1} and records what the
    // outputs must show: byte j finishes on dibit 4j+3, frame end is the first idle edge.
    task automatic run_frame(input logic [23:0] addr, input logic [7:0] seed, input int n_dibits,
                             input logic [7:0] a0, input logic [7:0] a1, input int n_idle,
                             input bit end_pulse);
        logic [7:0]    b [$];
        logic [7:0]    cur;
        logic [AW-1:0] a;
        int            start;
        int            j;
        int            slot;
        b.push_back(addr[23:16]);
        b.push_back(addr[15:8]);
        b.push_back(addr[7:0]);
        for (int k = 0; k < int'(PPL); k++) b.push_back(8'(k) ^ seed);
        b.push_back(a0);
        b.push_back(a1);
        start = cyc + 1;
        for (int i = 3; i < n_dibits; i += 4) begin
            j    = i / 4;
            slot = start + i;
            if (slot < MaxCyc) begin
                if (j >= 3 && j < 3 + int'(PPL)) begin
                    a              = addr[AW-1:0] + AW'(j - 3);
                    exp_en[slot]   = 1'b1;
                    exp_addr[slot] = a;
                    exp_data[slot] = b[j];
                end
`ifdef AUDIO_RX_EN
                else if (j >= 3 + int'(PPL)) begin
                    exp_av[slot] = 1'b1;
                    exp_ad[slot] = b[j];
                end
`endif
            end
        end
        slot = start + n_dibits;
        if (end_pulse && slot < MaxCyc) begin
            if (n_dibits >= Full) begin
`ifdef AUDIO_RX_EN
                if (n_dibits % 4 != 0) exp_err[slot] = 1'b1;
                else exp_done[slot] = 1'b1;
`else
                exp_done[slot] = 1'b1;
`endif
            end else begin
                exp_err[slot] = 1'b1;
            end
        end
        for (int i = 0; i < n_dibits; i++) begin
            cur = b[i / 4];
            step(1'b1, 1'b1, cur[2 * (i % 4) +: 2]);
        end
        for (int i = 0; i < n_idle; i++) step(1'b1, 1'b0, 2'b00);
    endtask

    int w0, d0, e0, a_0;

    task automatic snap();
        w0  = wr_log_addr.size();
        d0  = done_cnt;
        e0  = err_cnt;
        a_0 = av_log.size();
    endtask

    initial begin
        rst   = 1'b0;
        axiiv = 1'b0;
        axiid = 2'b00;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 2'b00);
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 2'b00);

        // Base frame at 0x140, pixel k = k mod 256.
        snap();
        run_frame(24'h000140, 8'h00, Full, 8'h00, 8'h00, 2, 1'b1);
        check("t1_writes", 32'(wr_log_addr.size() - w0), 32'd320);
        check("t1_first_addr", log_addr(w0), 32'h140);
        check("t1_last_addr", log_addr(w0 + 319), 32'h27F);
        check("t1_last_data", log_data(w0 + 319), 32'h3F);
        check("t1_done", 32'(done_cnt - d0), 32'd1);
        check("t1_err", 32'(err_cnt - e0), 32'd0);

        // Base near the top of the 17-bit space wraps to 0.
        snap();
        run_frame(24'h01FFF0, 8'h5A, Full, 8'h00, 8'h00, 1, 1'b1);
        check("t2_addr15", log_addr(w0 + 15), 32'h1FFFF);
        check("t2_addr16_wrap", log_addr(w0 + 16), 32'h00000);
        check("t2_data16", log_data(w0 + 16), 32'h4A);
        check("t2_done", 32'(done_cnt - d0), 32'd1);

        // Ends after 100 pixels plus 2 dibits.
        snap();
        run_frame(24'h000200, 8'h11, 12 + 400 + 2, 8'h00, 8'h00, 1, 1'b1);
        check("t3_writes", 32'(wr_log_addr.size() - w0), 32'd100);
        check("t3_err", 32'(err_cnt - e0), 32'd1);
        check("t3_done", 32'(done_cnt - d0), 32'd0);

        // Ends inside the address; next frame follows after a single idle cycle.
        snap();
        run_frame(24'h012345, 8'h00, 8, 8'h00, 8'h00, 1, 1'b1);
        check("t4_writes", 32'(wr_log_addr.size() - w0), 32'd0);
        check("t4_err", 32'(err_cnt - e0), 32'd1);
        snap();
        run_frame(24'h000000, 8'h33, Full, 8'h00, 8'h00, 2, 1'b1);
        check("t4b_writes", 32'(wr_log_addr.size() - w0), 32'd320);
        check("t4b_first_data", log_data(w0), 32'h33);
        check("t4b_done", 32'(done_cnt - d0), 32'd1);

        // Reset for 2 cycles after pixel 50 with the link still valid.
        snap();
        run_frame(24'h000400, 8'h77, 12 + 200, 8'h00, 8'h00, 0, 1'b0);
        step(1'b0, 1'b1, 2'b01);
        step(1'b0, 1'b1, 2'b10);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 2'(i));
        step(1'b1, 1'b0, 2'b00);
        check("t5_writes", 32'(wr_log_addr.size() - w0), 32'd50);
        check("t5_no_done", 32'(done_cnt - d0), 32'd0);
        check("t5_no_err", 32'(err_cnt - e0), 32'd0);
        snap();
        run_frame(24'h00ABCD, 8'hC3, Full, 8'h00, 8'h00, 2, 1'b1);
        check("t5b_writes", 32'(wr_log_addr.size() - w0), 32'd320);
        check("t5b_first_addr", log_addr(w0), 32'h0ABCD);
        check("t5b_done", 32'(done_cnt - d0), 32'd1);

        // Two trailing audio bytes.
        snap();
        run_frame(24'h000140, 8'h00, Full + 8, 8'hA5, 8'h3C, 2, 1'b1);
        check("t6_done", 32'(done_cnt - d0), 32'd1);
        check("t6_err", 32'(err_cnt - e0), 32'd0);
`ifdef AUDIO_RX_EN
        check("t6_audio_cnt", 32'(av_log.size() - a_0), 32'd2);
        check("t6_audio0", log_av(a_0), 32'hA5);
        check("t6_audio1", log_av(a_0 + 1), 32'h3C);
`else
        check("t6_audio_cnt", 32'(av_log.size() - a_0), 32'd0);
`endif

        // One audio byte plus a half byte.
        snap();
        run_frame(24'h000140, 8'h00, Full + 6, 8'hA5, 8'h3C, 2, 1'b1);
`ifdef AUDIO_RX_EN
        check("t7_audio_cnt", 32'(av_log.size() - a_0), 32'd1);
        check("t7_err", 32'(err_cnt - e0), 32'd1);
        check("t7_done", 32'(done_cnt - d0), 32'd0);
`else
        check("t7_audio_cnt", 32'(av_log.size() - a_0), 32'd0);
        check("t7_err", 32'(err_cnt - e0), 32'd0);
        check("t7_done", 32'(done_cnt - d0), 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
